timer_arbiter: RTL and testbench
================================

# timer_arbiter

Round-robin scheduler that shares one down-counting interval timer among `NUM_REQ` requesters. Each requester raises a level request with its interval length. The block grants the timer to one requester at a time, loads and runs the counter, and pulses `done_o` when the interval expires. It sits between the free-running counter datapath (`cnt_o` style, 8-bit) and any agents that need a timed window.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `CNT_W`, default 8: counter width.
- `clk`  in  1: the single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `req_i`  in  NUM_REQ: level request per requester; must stay high to keep a grant.
- `len_i`  in  NUM_REQ*CNT_W: interval length per requester; requester k uses bits [k*CNT_W +: CNT_W].
- `gnt_o`  out  NUM_REQ: one-hot grant; high for the whole owned interval.
- `done_o`  out  NUM_REQ: one-cycle completion pulse to the owner.
- `busy_o`  out  1: high while the timer is owned (state RUN).
- `owner_o`  out  $clog2(NUM_REQ): index of the current or last owner.
- `cnt_o`  out  CNT_W: current timer value.

## Operation
- FSM has two states.
  - IDLE: `gnt_o`=0, `busy_o`=0. If any `req_i` bit is high, select winner w by round-robin. At the edge: state←RUN, `gnt_o`←onehot(w), `owner_o`←w, `cnt_o`←len_i[w], last_ptr←w.
  - RUN: if `req_i[owner]`=0, abort: state←IDLE, `gnt_o`←0, `cnt_o`←0, no `done_o`. Else if `cnt_o`≠0: `cnt_o`←`cnt_o`−1. Else (`cnt_o`=0): state←IDLE, `gnt_o`←0, `done_o[owner]`←1.
- Round-robin search order is last_ptr+1, last_ptr+2, … modulo NUM_REQ. last_ptr resets to NUM_REQ−1, so requester 0 wins first.
- `len_i` is sampled only at the grant edge. Changes during RUN are ignored.
- len=0 is legal: the grant lasts exactly one cycle and is followed by `done_o`.
- Abort and expiry in the same cycle: abort wins, and no `done_o` is issued.
- `done_o` is registered and is zero in every cycle except the single IDLE cycle following expiry.
- Requests arriving during RUN wait. They are not queued beyond the level of `req_i`.
- `cnt_o` holds 0 in IDLE after an abort. After expiry it holds 0.

## Timing
- Reset values: state IDLE, `gnt_o`=0, `done_o`=0, `busy_o`=0, `owner_o`=0, `cnt_o`=0, last_ptr=NUM_REQ−1.
- Reset asserted mid-RUN clears everything at the next edge. No `done_o` is generated.
- The request is sampled in cycle T. `gnt_o`/`busy_o` are high from T+1 with `cnt_o`=L.
- `cnt_o` reaches 0 at T+1+L.
- `done_o` pulses at T+2+L, and `gnt_o` is low in that same cycle.
- Earliest next grant is T+3+L. The IDLE cycle carrying `done_o` performs arbitration. The back-to-back period is L+2 cycles.
- `busy_o` equals (state==RUN) and is updated on the same edge as `gnt_o`.

## Test plan
- Reset: hold `reset` for 2 cycles with `req_i`=4'b1111. Required: all outputs 0, no grant until the cycle after reset drops.
- Single request: requester 2, len 5, `req_i` raised at T. Required: `gnt_o`=4'b0100 and `cnt_o`=5 at T+1; `cnt_o` steps 5,4,3,2,1,0 through T+6; `done_o`=4'b0100 for one cycle at T+7 with `gnt_o`=0.
- Fairness: all four requesters held high, all len 3. Required: grant order 0,1,2,3,0,… with each grant 4 cycles long, new grant every 5 cycles, and exactly one `done_o` per grant.
- Zero length: requester 1, len 0. Required: `gnt_o`=4'b0010 for exactly one cycle with `cnt_o`=0, then `done_o`[1] pulse.
- Abort: requester 1, len 10; drop `req_i[1]` after 3 grant cycles while requester 2 waits. Required: `gnt_o`=0 at the next edge, no `done_o`, `cnt_o`=0; requester 2 is granted one cycle later. A separate case drops `req_i[owner]` in the `cnt_o`=0 cycle; required: no `done_o`.
- Reset mid-run: assert `reset` while `cnt_o`=4. Required: outputs return to reset values next cycle, no `done_o`, requester 0 wins first after release.

Source files
------------

// File: rtl/timer_arbiter_if.sv
// Request/grant bundle between the requesting agents and the shared interval timer.
// The master side raises requests and lengths; the slave side (the arbiter) returns grant and timer status.
interface timer_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
);
    localparam int OWN_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*CNT_W-1:0] len_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [NUM_REQ-1:0]       done_o;
    logic                     busy_o;
    logic [OWN_W-1:0]         owner_o;
    logic [CNT_W-1:0]         cnt_o;

    modport master (
        output req_i, len_i,
        input  gnt_o, done_o, busy_o, owner_o, cnt_o
    );

    modport slave (
        input  req_i, len_i,
        output gnt_o, done_o, busy_o, owner_o, cnt_o
    );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin owner of one down-counting interval timer shared by NUM_REQ requesters.
// A grant lasts len+1 cycles, is followed by a one-cycle done pulse, and is dropped early if the owner releases its request.
module timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    timer_arbiter_if.slave bus
);
    localparam int OWN_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    logic               busy_q;
    logic [OWN_W-1:0]   owner_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [OWN_W-1:0]   last_ptr_q;

    logic [OWN_W-1:0]   win_d;
    logic               any_req;

    // Scan from farthest to nearest so the candidate closest after last_ptr_q is written last and wins.
    always_comb begin
        win_d   = last_ptr_q;
        any_req = |bus.req_i;
        for (int i = NUM_REQ; i >= 1; i--) begin
            logic [OWN_W-1:0] cand;
            cand = OWN_W'((int'(last_ptr_q) + i) % NUM_REQ);
            if (bus.req_i[cand]) begin
                win_d = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            cnt_q      <= '0;
            last_ptr_q <= OWN_W'(NUM_REQ - 1);
        end else begin
            done_q <= '0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q    <= RUN;
                        gnt_q      <= NUM_REQ'(1) << win_d;
                        busy_q     <= 1'b1;
                        owner_q    <= win_d;
                        cnt_q      <= bus.len_i[win_d*CNT_W +: CNT_W];
                        last_ptr_q <= win_d;
                    end
                end
                RUN: begin
                    // Release by the owner takes priority over expiry, so no done pulse on abort.
                    if (!bus.req_i[owner_q]) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= NUM_REQ'(1) << owner_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt_o   = gnt_q;
    assign bus.done_o  = done_q;
    assign bus.busy_o  = busy_q;
    assign bus.owner_o = owner_q;
    assign bus.cnt_o   = cnt_q;
endmodule

// File: tb/tb_timer_arbiter.sv
// Vector-table bench for timer_arbiter: each record gives the inputs for one cycle and the outputs expected after that edge.
// Expected outputs are queued when a record is driven and popped for comparison once the edge has happened.
module tb_timer_arbiter;
    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] done;
        logic       busy;
        logic [1:0] owner;
        logic [7:0] cnt;
    } exp_t;

    typedef struct packed {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] len;
        exp_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    exp_t sb[$];

    timer_arbiter_if #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

    timer_arbiter #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lens(input logic [7:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [31:0] len,
                                input logic [3:0] gnt, input logic [3:0] done, input logic busy,
                                input logic [1:0] owner, input logic [7:0] cnt);
        vec_t v;
        v.rst       = rst;
        v.req       = req;
        v.len       = len;
        v.exp.gnt   = gnt;
        v.exp.done  = done;
        v.exp.busy  = busy;
        v.exp.owner = owner;
        v.exp.cnt   = cnt;
        return v;
    endfunction

    initial begin
        logic [31:0] l3s;
        exp_t e;
        exp_t act;
        l3s = lens(8'd3, 8'd3, 8'd3, 8'd3);

        // Reset held two cycles with all requests high.
        vecs.push_back(mk(1, 4'b1111, l3s, 4'b0000, 4'b0000, 0, 2'd0, 8'd0));
        vecs.push_back(mk(1, 4'b1111, l3s, 4'b0000, 4'b0000, 0, 2'd0, 8'd0));

        // Fairness: everyone requests, len 3 -> owners 0,1,2,3,0.. each 4 grant cycles then a done cycle.
        for (int g = 0; g < 8; g++) begin
            logic [1:0] o;
            o = 2'(g % 4);
            for (int c = 0; c < 4; c++)
                vecs.push_back(mk(0, 4'b1111, l3s, 4'b0001 << o, 4'b0000, 1, o, 8'(3 - c)));
            vecs.push_back(mk(0, 4'b1111, l3s, 4'b0000, 4'b0001 << o, 0, o, 8'd0));
        end
        vecs.push_back(mk(0, 4'b0000, l3s, 4'b0000, 4'b0000, 0, 2'd3, 8'd0));

        // Single request: requester 2, len 5.
        for (int c = 0; c <= 5; c++)
            vecs.push_back(mk(0, 4'b0100, lens(8'd0, 8'd0, 8'd5, 8'd0), 4'b0100, 4'b0000, 1, 2'd2, 8'(5 - c)));
        vecs.push_back(mk(0, 4'b0100, lens(8'd0, 8'd0, 8'd5, 8'd0), 4'b0000, 4'b0100, 0, 2'd2, 8'd0));
        vecs.push_back(mk(0, 4'b0000, lens(8'd0, 8'd0, 8'd5, 8'd0), 4'b0000, 4'b0000, 0, 2'd2, 8'd0));

        // Zero length: requester 1 owns exactly one cycle, then done.
        vecs.push_back(mk(0, 4'b0010, lens(8'd9, 8'd0, 8'd9, 8'd9), 4'b0010, 4'b0000, 1, 2'd1, 8'd0));
        vecs.push_back(mk(0, 4'b0010, lens(8'd9, 8'd0, 8'd9, 8'd9), 4'b0000, 4'b0010, 0, 2'd1, 8'd0));
        vecs.push_back(mk(0, 4'b0000, lens(8'd9, 8'd0, 8'd9, 8'd9), 4'b0000, 4'b0000, 0, 2'd1, 8'd0));

        // Abort: requester 1 len 10 dropped after 3 grant cycles while 2 waits; len change mid-run ignored.
        vecs.push_back(mk(0, 4'b0010, lens(8'd0, 8'd10, 8'd5, 8'd0), 4'b0010, 4'b0000, 1, 2'd1, 8'd10));
        vecs.push_back(mk(0, 4'b0110, lens(8'd0, 8'd77, 8'd5, 8'd0), 4'b0010, 4'b0000, 1, 2'd1, 8'd9));
        vecs.push_back(mk(0, 4'b0110, lens(8'd0, 8'd77, 8'd5, 8'd0), 4'b0010, 4'b0000, 1, 2'd1, 8'd8));
        vecs.push_back(mk(0, 4'b0100, lens(8'd0, 8'd77, 8'd5, 8'd0), 4'b0000, 4'b0000, 0, 2'd1, 8'd0));
        vecs.push_back(mk(0, 4'b0100, lens(8'd0, 8'd77, 8'd5, 8'd0), 4'b0100, 4'b0000, 1, 2'd2, 8'd5));
        vecs.push_back(mk(0, 4'b0000, lens(8'd0, 8'd77, 8'd5, 8'd0), 4'b0000, 4'b0000, 0, 2'd2, 8'd0));

        // Abort in the cnt=0 cycle: no done pulse.
        vecs.push_back(mk(0, 4'b1000, lens(8'd0, 8'd0, 8'd0, 8'd1), 4'b1000, 4'b0000, 1, 2'd3, 8'd1));
        vecs.push_back(mk(0, 4'b1000, lens(8'd0, 8'd0, 8'd0, 8'd1), 4'b1000, 4'b0000, 1, 2'd3, 8'd0));
        vecs.push_back(mk(0, 4'b0000, lens(8'd0, 8'd0, 8'd0, 8'd1), 4'b0000, 4'b0000, 0, 2'd3, 8'd0));
        vecs.push_back(mk(0, 4'b0000, lens(8'd0, 8'd0, 8'd0, 8'd1), 4'b0000, 4'b0000, 0, 2'd3, 8'd0));

        // Reset mid-run at cnt=4, then requester 0 must beat requester 3.
        vecs.push_back(mk(0, 4'b0100, lens(8'd2, 8'd0, 8'd6, 8'd1), 4'b0100, 4'b0000, 1, 2'd2, 8'd6));
        vecs.push_back(mk(0, 4'b0100, lens(8'd2, 8'd0, 8'd6, 8'd1), 4'b0100, 4'b0000, 1, 2'd2, 8'd5));
        vecs.push_back(mk(0, 4'b0100, lens(8'd2, 8'd0, 8'd6, 8'd1), 4'b0100, 4'b0000, 1, 2'd2, 8'd4));
        vecs.push_back(mk(1, 4'b0100, lens(8'd2, 8'd0, 8'd6, 8'd1), 4'b0000, 4'b0000, 0, 2'd0, 8'd0));
        vecs.push_back(mk(0, 4'b1001, lens(8'd2, 8'd0, 8'd6, 8'd1), 4'b0001, 4'b0000, 1, 2'd0, 8'd2));
        vecs.push_back(mk(0, 4'b1001, lens(8'd2, 8'd0, 8'd6, 8'd1), 4'b0001, 4'b0000, 1, 2'd0, 8'd1));
        vecs.push_back(mk(0, 4'b1001, lens(8'd2, 8'd0, 8'd6, 8'd1), 4'b0001, 4'b0000, 1, 2'd0, 8'd0));
        vecs.push_back(mk(0, 4'b1001, lens(8'd2, 8'd0, 8'd6, 8'd1), 4'b0000, 4'b0001, 0, 2'd0, 8'd0));
        vecs.push_back(mk(0, 4'b1001, lens(8'd2, 8'd0, 8'd6, 8'd1), 4'b1000, 4'b0000, 1, 2'd3, 8'd1));
        vecs.push_back(mk(0, 4'b0000, lens(8'd2, 8'd0, 8'd6, 8'd1), 4'b0000, 4'b0000, 0, 2'd3, 8'd0));

        reset       = 1'b1;
        bus.req_i   = '0;
        bus.len_i   = '0;
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            reset     = vecs[k].rst;
            bus.req_i = vecs[k].req;
            bus.len_i = vecs[k].len;
            sb.push_back(vecs[k].exp);
            @(posedge clk);
            #1;
            e           = sb.pop_front();
            act.gnt     = bus.gnt_o;
            act.done    = bus.done_o;
            act.busy    = bus.busy_o;
            act.owner   = bus.owner_o;
            act.cnt     = bus.cnt_o;
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL vec%0d: got gnt=%b done=%b busy=%b owner=%0d cnt=%0d, required gnt=%b done=%b busy=%b owner=%0d cnt=%0d",
                         k, act.gnt, act.done, act.busy, act.owner, act.cnt,
                         e.gnt, e.done, e.busy, e.owner, e.cnt);
            end else begin
                $display("vec%0d req=%b rst=%b -> gnt=%b done=%b busy=%b owner=%0d cnt=%0d",
                         k, vecs[k].req, vecs[k].rst, act.gnt, act.done, act.busy, act.owner, act.cnt);
            end
        end

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
